// File: rtl/nn_fixed_pkg.sv
// Shared Q4.12 fixed-point types, limits and the round/saturate helper
// used by the neuron MAC and the activation stage.
package nn_fixed_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC_W = 12;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef logic signed [DATA_W-1:0] q4_12_t;

  localparam q4_12_t Q_MIN = 16'h8000;
  localparam q4_12_t Q_MAX = 16'h7FFF;

  // Rounded, clipped Q4.12 value plus the clip flag
  typedef struct packed {
    logic   sat;
    q4_12_t sum;
  } round_res_t;

  // Round a Q(ACC_W-24).24 value half-up to Q4.12 and saturate
  function automatic round_res_t sat_round(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] r;
    round_res_t            res;
    ext = {acc[ACC_W-1], acc};
    r   = (ext + ((ACC_W+1)'(1) <<< (FRAC_W-1))) >>> FRAC_W;
    // r fits in DATA_W bits only when every bit above the sign bit matches it
    if (r[ACC_W:DATA_W-1] != {(ACC_W-DATA_W+2){r[ACC_W]}}) begin
      res.sat = 1'b1;
      res.sum = r[ACC_W] ? Q_MIN : Q_MAX;
    end else begin
      res.sat = 1'b0;
      res.sum = r[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/q_round_sat.sv
// Combinational accumulator-to-Q4.12 round-half-up with saturation flag.
module q_round_sat
  import nn_fixed_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  output q4_12_t                  sum_c,
  output logic                    sat_c
);

  round_res_t res;

  // Narrow the accumulator through the shared helper
  always_comb begin
    res   = sat_round(acc);
    sum_c = res.sum;
    sat_c = res.sat;
  end

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: streams x/w pairs, adds bias, rounds
// and saturates the pre-activation sum to Q4.12 for the sigmoid lookup.
module neuron_mac
  import nn_fixed_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_w,
  input  logic [DATA_W-1:0] in_bias,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_sat
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACCUM = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] ROUND = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  logic [2:0]              state;
  logic [2:0]              state_n;
  logic signed [ACC_W-1:0] acc;
  logic signed [PROD_W-1:0] prod_q;
  logic                    prod_vld;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0] prod_ext_c;
  logic signed [ACC_W-1:0] bias_ext_c;
  logic                    beat_c;
  q4_12_t                  rnd_sum_c;
  logic                    rnd_sat_c;

  assign beat_c     = in_valid && in_ready;
  assign prod_c     = $signed(in_x) * $signed(in_w);
  assign prod_ext_c = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
  assign bias_ext_c = {{(ACC_W-DATA_W-FRAC_W){in_bias[DATA_W-1]}}, in_bias, {FRAC_W{1'b0}}};

  q_round_sat u_round (
    .acc   (acc),
    .sum_c (rnd_sum_c),
    .sat_c (rnd_sat_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (beat_c) state_n = in_last ? DRAIN : ACCUM;
      ACCUM:   if (beat_c && in_last) state_n = DRAIN;
      DRAIN:   state_n = ROUND;
      ROUND:   state_n = OUT;
      OUT:     if (out_valid && out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      acc       <= '0;
      prod_q    <= '0;
      prod_vld  <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE) || (state_n == ACCUM);
      out_valid <= (state_n == OUT);
      case (state)
        IDLE: begin
          if (beat_c) begin
            acc      <= bias_ext_c;
            prod_q   <= prod_c;
            prod_vld <= 1'b1;
          end
        end
        ACCUM: begin
          // Product pipeline: add last cycle's product, capture this one
          acc      <= acc + (prod_vld ? prod_ext_c : '0);
          prod_vld <= beat_c;
          if (beat_c) prod_q <= prod_c;
        end
        DRAIN: begin
          acc      <= acc + prod_ext_c;
          prod_vld <= 1'b0;
        end
        ROUND: begin
          out_sum <= rnd_sum_c;
          out_sat <= rnd_sat_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Single-neuron multiply-accumulate stage that produces the pre-activation sum feeding the sigmoid activation lookup. It accepts a stream of signed Q4.12 input/weight pairs over a valid/ready handshake and adds a Q4.12 bias. It rounds and saturates the result back to signed Q4.12 and presents it, with a saturation flag, on a valid/ready output port. Its `out_sum` connects directly to the activation block's `x` input.

## Interface
- `DATA_W`, 16: width of x, w, bias and result; fixed-point signed two's complement.
- `FRAC_W`, 12: fractional bits (Q4.12).
- `ACC_W`, 40: accumulator width; signed, Q(ACC_W-24).24.
- `clk`  in  1  rising-edge clock; the block uses one clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_x`  in  DATA_W  input activation, Q4.12.
- `in_w`  in  DATA_W  weight, Q4.12.
- `in_bias`  in  DATA_W  bias, Q4.12; sampled only on the first beat of a vector.
- `in_last`  in  1  marks the final beat of the vector.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  DATA_W  rounded, saturated sum, Q4.12.
- `out_sat`  out  1  high when `out_sum` was clipped.

## Operation
- A beat transfers on a rising edge where `in_valid && in_ready`. An output transfers on a rising edge where `out_valid && out_ready`.
- FSM states: IDLE, ACCUM, DRAIN, ROUND, OUT.
- **IDLE**
  - `in_ready`=1.
  - On a beat: `acc <= sign_ext(in_bias) << FRAC_W`, `prod_q <= in_x*in_w` (32-bit signed, Q8.24).
  - Next state is DRAIN if `in_last`, else ACCUM.
- **ACCUM**
  - `in_ready`=1.
  - Every edge: `acc <= acc + prod_v` (prod_v is prod_q if the product-valid bit is set, else 0).
  - On a beat: `prod_q` loads the new product and the product-valid bit is set. Otherwise the product-valid bit clears.
  - On a beat with `in_last`: next state is DRAIN.
  - Input bubbles (`in_valid`=0) are legal and do not change the accumulated value.
- **DRAIN**
  - `in_ready`=0.
  - `acc <= acc + prod_q` (the final product); next state is ROUND.
- **ROUND**
  - `in_ready`=0.
  - Compute `r = (acc + 2^(FRAC_W-1)) >>> FRAC_W`: arithmetic shift, round-half-up toward +inf.
  - If r > 32767: `out_sum <= 0x7FFF`, `out_sat <= 1`.
  - If r < -32768: `out_sum <= 0x8000`, `out_sat <= 1`.
  - Otherwise `out_sum <= r[15:0]`, `out_sat <= 0`.
  - Next state is OUT.
- **OUT**
  - `out_valid`=1 and `in_ready`=0.
  - `out_sum` and `out_sat` are held stable until the transfer, then the FSM goes to IDLE.
  - The next vector's first beat is accepted no earlier than the edge after the output transfer.
- Accumulator overflow is not detected. ACC_W=40 gives ≥2^8 worst-case full-scale terms of headroom, and vectors are limited to 256 beats by system contract.

## Timing
- Reset values:
  - `in_ready`=0 during the reset cycle, 1 from the first cycle after reset deasserts (IDLE).
  - `out_valid`=0, `out_sum`=0x0000, `out_sat`=0.
  - `acc`=0, `prod_q`=0, product-valid bit 0.
- Latency: the `in_last` beat accepted at edge E0 gives `out_valid`=1 after edge E0+2 (DRAIN at E1, ROUND at E2).
- Throughput: one beat per cycle while in ACCUM. Per-vector overhead is 3 cycles plus the output wait.
- `rst` asserted in any state, including mid-vector or during OUT with the output not yet transferred, returns the FSM to IDLE next edge. That vector's partial sum is discarded; no output is produced for it.
- `in_valid` in DRAIN, ROUND or OUT is ignored (`in_ready`=0). The upstream must hold the beat.

## Structure
- Shared package `nn_fixed_pkg`:
  - DATA_W/FRAC_W constants.
  - `q4_12_t` typedef (signed [15:0]).
  - Q4.12 min/max constants (0x8000/0x7FFF).
  - `sat_round` function.
  - The activation stage reuses the same package.
- FSM state enum is local.
- One natural sub-module, `q_round_sat`: a combinational ACC_W→DATA_W round-half-up plus saturation with a flag, instantiated in ROUND.

## Test plan
- Single beat: x=0x1000 (1.0), w=0x0800 (0.5), bias=0, `in_last`=1 → `out_sum`=0x0800, `out_sat`=0, `out_valid` 2 cycles after acceptance.
- Three beats with bias: x/w = (0xF000,0x2000), (0x0400,0x1000), (0x0000,0x7FFF), bias=0x0400 → -2+0.25+0+0.25 = -1.5 → `out_sum`=0xE800.
- Rounding: x=0x0001, w=0x0800, bias=0 → product 0x800 in Q8.24 → `out_sum`=0x0001. Repeat with w=0x07FF → 0x0000.
- Saturation:
  - 4 beats x=w=0x7FFF → `out_sum`=0x7FFF, `out_sat`=1.
  - 4 beats x=0x7FFF, w=0x8000 → `out_sum`=0x8000, `out_sat`=1.
- Backpressure and bubbles:
  - `out_ready`=0 for 5 cycles → `out_sum` stable, `in_ready`=0 throughout; transfer on the first `out_ready`=1, IDLE next cycle.
  - Random `in_valid` gaps give the same result as a gapless stream.
- Reset mid-vector: `rst` after 2 of 4 beats; then a fresh single beat x=0x1000, w=0x1000 → `out_sum`=0x1000, with no residue from the aborted vector.
